// File: rtl/bin16_to_bcd.sv
// bin16_to_bcd: sequential double-dabble converter, 16-bit binary to five packed BCD digits,
// valid/ready on both sides, one bit per cycle over 16 SHIFT cycles.
module bin16_to_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] bcd,
  output logic        busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  logic [1:0]  r_state;
  logic [15:0] r_sh;
  logic [19:0] r_scr;
  logic [19:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [19:0] w_adj;
  logic [35:0] w_cat;
  // add-3 correction is per digit; a digit <= 9 plus 3 never exceeds 4 bits
  for (genvar d = 0; d < 5; d++) begin : g_adj
    assign w_adj[4*d+:4] = r_scr[4*d+:4] >= 4'd5 ? r_scr[4*d+:4] + 4'd3 : r_scr[4*d+:4];
  end
  assign w_cat = {w_adj, r_sh} << 1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else if (r_state == S_IDLE) begin
      if (in_valid) begin
        r_state <= S_SHIFT;
        r_sh    <= bin;
        r_scr   <= '0;
        r_cnt   <= '0;
      end
    end else if (r_state == S_SHIFT) begin
      r_scr <= w_cat[35:16];
      r_sh  <= w_cat[15:0];
      r_cnt <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) begin
        r_bcd   <= w_cat[35:16];
        r_state <= S_DONE;
      end
    end else if (r_state == S_DONE) begin
      if (out_ready) r_state <= S_IDLE;
    end else begin
      r_state <= S_IDLE;
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign busy      = r_state == S_SHIFT;
  assign bcd       = r_bcd;
endmodule
